// File: rtl/branch_pc_unit_pkg.sv
// Shared CPU definitions for the fetch/branch unit: branch classes and
// the fixed fetch addresses of the memory map.
package branch_pc_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_BCOND = 3'd1,
    BR_J     = 3'd2,
    BR_JAL   = 3'd3,
    BR_JR    = 3'd4
  } br_type_e;

  localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PKG_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] PKG_IM_LO    = 32'h0000_3000;
  localparam logic [31:0] PKG_IM_HI    = 32'h0000_6FFC;

  // Only the defined non-NONE classes open a delay slot; other codes act as NONE.
  function automatic logic is_branch(input logic [2:0] bt);
    return (bt == BR_BCOND) || (bt == BR_J) || (bt == BR_JAL) || (bt == BR_JR);
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Pipeline-side bundle of the fetch/branch unit: D/M-stage controls in,
// fetch PC and delay-slot flag out. All signals are level, no handshake.
interface branch_pc_unit_if;
  import branch_pc_unit_pkg::*;

  logic        stall;
  logic [2:0]  br_type;
  logic [31:0] cmp_o;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic [31:0] pc_d;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic        bd_d;
  logic        adel_f;

  modport slave (
    input  stall, br_type, cmp_o, imm16, instr_index, rs_val, pc_d,
           exc_req, eret, epc,
    output pc_f, bd_d, adel_f
  );

  modport master (
    output stall, br_type, cmp_o, imm16, instr_index, rs_val, pc_d,
           exc_req, eret, epc,
    input  pc_f, bd_d, adel_f
  );
endinterface

// File: rtl/branch_pc_unit_npc_calc.sv
// Combinational next-PC for an unstalled, non-exceptional edge, chosen by
// the branch class of the instruction in D.
module npc_calc
  import branch_pc_unit_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [2:0]  br_type,
  input  logic        cmp_true,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign seq_pc    = pc_f + 32'd4;
  // Branch offset is relative to the delay slot, i.e. pc_d + 4.
  assign br_target = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_d[31:28], instr_index, 2'b00};

  always_comb begin
    npc = seq_pc;
    case (br_type)
      BR_BCOND: npc = cmp_true ? br_target : seq_pc;
      BR_J,
      BR_JAL:   npc = j_target;
      BR_JR:    npc = rs_val;
      default:  npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register with exception/ERET/stall/redirect priority and the
// delay-slot flag for the instruction entering D.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PKG_RESET_PC,
  parameter logic [31:0] EXC_PC   = PKG_EXC_PC,
  parameter logic [31:0] IM_LO    = PKG_IM_LO,
  parameter logic [31:0] IM_HI    = PKG_IM_HI
) (
  input  logic               clk,
  input  logic               reset_n,
  branch_pc_unit_if.slave    bus
);

  logic [31:0] pc_q, pc_next, npc;
  logic        bd_q, bd_next;
  logic        unused_cmp_hi;

  assign unused_cmp_hi = ^bus.cmp_o[31:1];

  npc_calc u_npc_calc (
    .pc_f        (pc_q),
    .pc_d        (bus.pc_d),
    .br_type     (bus.br_type),
    .cmp_true    (bus.cmp_o[0]),
    .imm16       (bus.imm16),
    .instr_index (bus.instr_index),
    .rs_val      (bus.rs_val),
    .npc         (npc)
  );

  always_comb begin
    pc_next = pc_q;
    bd_next = bd_q;
    if (bus.exc_req) begin
      pc_next = EXC_PC;
      bd_next = 1'b0;
    end else if (bus.eret) begin
      pc_next = bus.epc;
      bd_next = 1'b0;
    end else if (!bus.stall) begin
      pc_next = npc;
      bd_next = is_branch(bus.br_type);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_next;
      bd_q <= bd_next;
    end
  end

  assign bus.pc_f   = pc_q;
  assign bus.bd_d   = bd_q;
  // Fetch address error is only flagged; the PC is never redirected by it.
  assign bus.adel_f = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed vector table, async-reset sequences,
// then random stimulus against an arithmetic reference model.
module tb_branch_pc_unit;
  import branch_pc_unit_pkg::*;

  localparam logic [31:0] R_PC  = 32'h0000_3000;
  localparam logic [31:0] X_PC  = 32'h0000_4180;
  localparam logic [31:0] LO    = 32'h0000_3000;
  localparam logic [31:0] HI    = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_pc_unit_if bus ();

  branch_pc_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        stall;
    logic [2:0]  br_type;
    logic [31:0] cmp_o;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic [31:0] pc_d;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic        exp_bd;
    logic        exp_adel;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_bd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic stall, input logic [2:0] bt, input logic [31:0] cmp,
                              input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] rs, input logic [31:0] pcd,
                              input logic exc, input logic er, input logic [31:0] ep,
                              input logic [31:0] epc_exp, input logic ebd, input logic eadel);
    vec_t v;
    v.stall = stall; v.br_type = bt; v.cmp_o = cmp; v.imm16 = imm;
    v.instr_index = idx; v.rs_val = rs; v.pc_d = pcd; v.exc_req = exc;
    v.eret = er; v.epc = ep; v.exp_pc = epc_exp; v.exp_bd = ebd; v.exp_adel = eadel;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.stall = v.stall; bus.br_type = v.br_type; bus.cmp_o = v.cmp_o;
    bus.imm16 = v.imm16; bus.instr_index = v.instr_index; bus.rs_val = v.rs_val;
    bus.pc_d = v.pc_d; bus.exc_req = v.exc_req; bus.eret = v.eret; bus.epc = v.epc;
  endtask

  function automatic logic model_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < LO) || (pc > HI);
  endfunction

  // Next fetch PC from the architectural rules, using plain integer arithmetic.
  task automatic model_step(input vec_t v);
    longint off;
    if (v.exc_req) begin
      m_pc = X_PC; m_bd = 1'b0;
    end else if (v.eret) begin
      m_pc = v.epc; m_bd = 1'b0;
    end else if (!v.stall) begin
      m_bd = 1'b1;
      if (v.br_type == 3'd1) begin
        off = 4 * longint'($signed(v.imm16));
        m_pc = v.cmp_o[0] ? 32'(longint'(v.pc_d) + 4 + off) : 32'(longint'(m_pc) + 4);
      end else if (v.br_type == 3'd2 || v.br_type == 3'd3) begin
        m_pc = (v.pc_d & 32'hF000_0000) | (32'(v.instr_index) * 4);
      end else if (v.br_type == 3'd4) begin
        m_pc = v.rs_val;
      end else begin
        m_pc = 32'(longint'(m_pc) + 4);
        m_bd = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] pc,
                               input logic bd, input logic adel);
    check({tag, ".pc_f"},   bus.pc_f,          pc);
    check({tag, ".bd_d"},   32'(bus.bd_d),     32'(bd));
    check({tag, ".adel_f"}, 32'(bus.adel_f),   32'(adel));
  endtask

  // Pulse reset between edges; outputs must change without a clock edge.
  task automatic reset_pulse(input string tag);
    #1 reset_n = 1'b0;
    #1;
    check_outputs({tag, ".async_rst"}, R_PC, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    m_pc = R_PC; m_bd = 1'b0;
  endtask

  vec_t v;
  vec_t idle;

  initial begin
    idle = mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);

    // NONE from reset
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300C, 0, 0));
    // BCOND taken back-branch (0x3004 + 4 - 4), then not-taken with high cmp bits set
    tbl.push_back(mk(0, 3'd1, 32'h1, 16'hFFFF, 0, 0, 32'h3004, 0, 0, 0, 32'h3004, 1, 0));
    tbl.push_back(mk(0, 3'd1, 32'hFFFF_FFFE, 16'hFFFF, 0, 0, 32'h3004, 0, 0, 0, 32'h3008, 1, 0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300C, 0, 0));
    // Stalled J ignored for two edges, acted on when re-presented
    tbl.push_back(mk(1, 3'd2, 0, 0, 26'hC10, 0, 32'h3010, 0, 0, 0, 32'h300C, 0, 0));
    tbl.push_back(mk(1, 3'd2, 0, 0, 26'hC10, 0, 32'h3010, 0, 0, 0, 32'h300C, 0, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, 26'hC10, 0, 32'h3010, 0, 0, 0, 32'h3040, 1, 0));
    // Exception beats everything, then ERET
    tbl.push_back(mk(1, 3'd4, 0, 0, 0, 32'h5000, 0, 1, 1, 32'h3100, 32'h4180, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 32'h3020, 32'h3020, 0, 0));
    // JR misaligned and top of range, then run off the end
    tbl.push_back(mk(0, 3'd4, 0, 0, 0, 32'h3002, 0, 0, 0, 0, 32'h3002, 1, 1));
    tbl.push_back(mk(0, 3'd4, 0, 0, 0, 32'h6FFC, 0, 0, 0, 0, 32'h6FFC, 1, 0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000, 0, 1));
    // Undefined encoding acts as NONE
    tbl.push_back(mk(0, 3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7004, 0, 1));
    // JAL keeps pc_d region bits
    tbl.push_back(mk(0, 3'd3, 0, 0, 26'h3FF_FFFF, 0, 32'hA000_0000, 0, 0, 0, 32'hAFFF_FFFC, 1, 1));
    // ERET overrides stall
    tbl.push_back(mk(1, 3'd2, 0, 0, 0, 0, 0, 0, 1, 32'h3100, 32'h3100, 0, 0));
    // Taken branch wraps modulo 2^32, then stall holds bd_d=1
    tbl.push_back(mk(0, 3'd1, 32'h1, 16'h0001, 0, 0, 32'hFFFF_FFF8, 0, 0, 0, 32'h0000_0000, 1, 1));
    tbl.push_back(mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 1));
    tbl.push_back(mk(0, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0004, 0, 1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", R_PC, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_bd, tbl[i].exp_adel);
    end

    // Reset while stalled at 0x3050
    reset_pulse("pre");
    drive(mk(0, 3'd2, 0, 0, 26'hC14, 0, 32'h3000, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check_outputs("to_3050", 32'h3050, 1'b1, 1'b0);
    drive(mk(1, 3'd2, 0, 0, 26'h100, 0, 32'h3000, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check_outputs("stall_3050", 32'h3050, 1'b1, 1'b0);
    reset_pulse("stall_rst");
    drive(idle);
    @(posedge clk); #1;
    check_outputs("after_rst", 32'h3004, 1'b0, 1'b0);

    // Reset held across an edge with a redirect pending discards it
    drive(mk(0, 3'd4, 0, 0, 0, 32'h5554, 0, 0, 0, 0, 0, 0, 0));
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    check_outputs("rst_over_jr", R_PC, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(idle);
    @(posedge clk); #1;
    check_outputs("rst_over_jr_next", 32'h3004, 1'b0, 1'b0);
    m_pc = 32'h3004; m_bd = 1'b0;

    // Random phase against the reference model
    for (int n = 0; n < 400; n++) begin
      v = idle;
      v.stall       = ($urandom_range(0, 3) == 0);
      v.br_type     = 3'($urandom_range(0, 7));
      v.cmp_o       = $urandom;
      v.imm16       = 16'($urandom);
      v.instr_index = 26'($urandom);
      v.pc_d        = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 4095)) * 4);
      v.rs_val      = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 4095)) * 4);
      v.exc_req     = ($urandom_range(0, 19) == 0);
      v.eret        = ($urandom_range(0, 14) == 0);
      v.epc         = 32'h3000 + 32'($urandom_range(0, 16383));
      if ($urandom_range(0, 49) == 0) reset_pulse($sformatf("rnd%0d", n));
      drive(v);
      model_step(v);
      @(posedge clk); #1;
      check_outputs($sformatf("rnd%0d", n), m_pc, m_bd, model_adel(m_pc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
